// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-limited imem requests, in-order tagged responses,
// prefetch FIFO toward decode, redirect flush. Optional perf counters: IF_PERF_CNT_EN.
module if_fetch_unit #(
    parameter int          PC_W     = 16,
    parameter int          INSN_W   = 16,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0,
    parameter int          REG_AW   = 3,
    parameter int          RS1_LSB  = 6,
    parameter int          RS2_LSB  = 3,
    parameter int          RD_LSB   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] out_insn,
    output logic [PC_W-1:0]   out_pc,
    output logic [REG_AW-1:0] read1_addr,
    output logic [REG_AW-1:0] read2_addr,
    output logic [REG_AW-1:0] write_addr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  infl_q, infl_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [PTR_W-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [PC_W-1:0]   tag_mem       [DEPTH];
    logic [PC_W-1:0]   fifo_pc_mem   [DEPTH];
    logic [INSN_W-1:0] fifo_insn_mem [DEPTH];

    logic credit, req_fire, rsp_drop, push, pop, fifo_full;

    // Credit covers both in-flight responses and buffered entries, so a response always finds room.
    assign credit    = ({1'b0, infl_q} + {1'b0, fifo_cnt_q}) < (CNT_W+1)'(DEPTH);
    assign fifo_full = (fifo_cnt_q == CNT_W'(DEPTH));

    assign imem_req_valid = credit && !redirect_valid && rst_n;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (redirect_valid || (drop_q != '0));
    assign push     = imem_rsp_valid && !rsp_drop;

    assign out_valid  = (fifo_cnt_q != '0) && !redirect_valid;
    assign pop        = out_valid && out_ready;
    assign out_insn   = fifo_insn_mem[fifo_rd_q];
    assign out_pc     = fifo_pc_mem[fifo_rd_q];
    assign read1_addr = out_insn[RS1_LSB +: REG_AW];
    assign read2_addr = out_insn[RS2_LSB +: REG_AW];
    assign write_addr = out_insn[RD_LSB +: REG_AW];

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        fetch_pc_d = fetch_pc_q;
        infl_d     = infl_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_d     = drop_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_W'(1);
            tag_wr_d   = tag_wr_q + PTR_W'(1);
        end
        if (imem_rsp_valid) begin
            tag_rd_d = tag_rd_q + PTR_W'(1);
            if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
        end
        if (push) fifo_wr_d = fifo_wr_q + PTR_W'(1);
        if (pop)  fifo_rd_d = fifo_rd_q + PTR_W'(1);

        // Redirect wins: every response still outstanding after this cycle is stale.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            fifo_cnt_d = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            drop_d     = infl_q - CNT_W'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignment so all of them update from pre-edge values.
        if (!rst_n) begin
            fetch_pc_q <= PC_W'(RESET_PC);
            infl_q     <= '0;
            drop_q     <= '0;
            fifo_cnt_q <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_q     <= infl_d;
            drop_q     <= drop_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    // NOTE: storage arrays are not reset; counters and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (req_fire) tag_mem[tag_wr_q] <= imem_req_addr;
        if (push) begin
            fifo_pc_mem[fifo_wr_q]   <= tag_mem[tag_rd_q];
            fifo_insn_mem[fifo_wr_q] <= imem_rsp_data;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_flushed_d = perf_flushed_q + (redirect_valid ? 32'(fifo_cnt_q) : 32'd0) + 32'(rsp_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a one-cycle-latency in-order memory model that can be held.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_insn;
    logic [15:0] out_pc;
    logic [2:0]  read1_addr, read2_addr, write_addr;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_req = 0;
    bit          mem_hold = 1'b0;
    logic [15:0] pend[$];

    if_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_insn       (out_insn),
        .out_pc         (out_pc),
        .read1_addr     (read1_addr),
        .read2_addr     (read2_addr),
        .write_addr     (write_addr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] insn_of(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Finish the current cycle; memory answers each accepted request the following cycle unless held.
    task automatic cyc();
        bit          acc;
        logic [15:0] a;
        #1;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            pend.push_back(a);
            n_req++;
        end
        if (!mem_hold && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = insn_of(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_hold       = 1'b0;
        pend.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_req = 0;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b1;

        @(negedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
`ifdef IF_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 0);
        check("rst_perf_flushed", perf_flushed, 0);
`endif

        // Streaming from reset at one instruction per cycle
        do_reset();
        check("t1_c0_req_valid", imem_req_valid, 1);
        check("t1_c0_addr", imem_req_addr, 16'h0000);
        cyc();
        check("t1_c1_addr", imem_req_addr, 16'h0001);
        check("t1_c1_out_valid", out_valid, 0);
        cyc();
        check("t1_c2_out_valid", out_valid, 1);
        check("t1_c2_out_pc", out_pc, 16'h0000);
        check("t1_c2_out_insn", out_insn, 16'h5A3C);
        check("t1_c2_read1", read1_addr, 3'd0);
        check("t1_c2_read2", read2_addr, 3'd7);
        check("t1_c2_write", write_addr, 3'd5);
        for (int k = 3; k < 8; k++) begin
            cyc();
            check("t1_out_valid", out_valid, 1);
            check("t1_out_pc", out_pc, 16'(k - 2));
            check("t1_out_insn", out_insn, insn_of(16'(k - 2)));
            check("t1_addr", imem_req_addr, 16'(k));
        end

        // Decode stalled: credit caps outstanding work at DEPTH
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) cyc();
        check("t2_req_count", n_req, 4);
        check("t2_stall_req_valid", imem_req_valid, 0);
        check("t2_stall_out_pc", out_pc, 16'h0000);
        out_ready = 1'b1;
        #1;
        check("t2_pop_cycle_req_valid", imem_req_valid, 0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            if (k == 1) begin
                check("t2_resume_req_valid", imem_req_valid, 1);
                check("t2_resume_addr", imem_req_addr, 16'h0004);
            end
            check("t2_out_valid", out_valid, 1);
            check("t2_out_pc", out_pc, 16'(k));
        end

        // Redirect with two responses in flight and two buffered entries
        out_ready = 1'b0;
        do_reset();
        cyc();
        cyc();
        mem_hold = 1'b1;
        cyc();
        cyc();
        check("t3_pre_req_valid", imem_req_valid, 0);
        check("t3_pre_out_pc", out_pc, 16'h0000);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        mem_hold       = 1'b0;
        #1;
        check("t3_redir_req_valid", imem_req_valid, 0);
        check("t3_redir_out_valid", out_valid, 0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("t3_n1_req_valid", imem_req_valid, 1);
        check("t3_n1_addr", imem_req_addr, 16'h0040);
        check("t3_n1_out_valid", out_valid, 0);
        cyc();
        check("t3_n2_addr", imem_req_addr, 16'h0041);
        check("t3_n2_out_valid", out_valid, 0);
        cyc();
        check("t3_n3_out_valid", out_valid, 0);
        cyc();
        check("t3_n4_out_valid", out_valid, 1);
        check("t3_n4_out_pc", out_pc, 16'h0040);
        check("t3_n4_out_insn", out_insn, 16'h5A7C);
        check("t3_n4_read1", read1_addr, 3'd1);
`ifdef IF_PERF_CNT_EN
        check("t3_perf_flushed", perf_flushed, 4);
`endif

        // Redirect coinciding with a response and a pop attempt
        out_ready = 1'b1;
        do_reset();
        cyc();
        cyc();
        cyc();
        check("t4_pre_out_pc", out_pc, 16'h0001);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        #1;
        check("t4_redir_out_valid", out_valid, 0);
        check("t4_redir_req_valid", imem_req_valid, 0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("t4_n1_addr", imem_req_addr, 16'h0100);
        check("t4_n1_out_valid", out_valid, 0);
        cyc();
        check("t4_n2_out_valid", out_valid, 0);
        cyc();
        check("t4_n3_out_valid", out_valid, 1);
        check("t4_n3_out_pc", out_pc, 16'h0100);
`ifdef IF_PERF_CNT_EN
        check("t4_perf_fetched", perf_fetched, 1);
`endif

        // Back-to-back redirects (last wins) into a PC wrap
        do_reset();
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h1234;
        cyc();
        redirect_pc = 16'hFFFF;
        #1;
        check("t5_b2b_req_valid", imem_req_valid, 0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("t5_addr_ffff", imem_req_addr, 16'hFFFF);
        cyc();
        check("t5_addr_wrap", imem_req_addr, 16'h0000);
        cyc();
        check("t5_out_pc_ffff", out_pc, 16'hFFFF);
        check("t5_out_insn_ffff", out_insn, 16'hA5C3);
        cyc();
        check("t5_out_valid_wrap", out_valid, 1);
        check("t5_out_pc_wrap", out_pc, 16'h0000);

        // Reset pulsed mid-stream
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_req_valid", imem_req_valid, 0);
        do_reset();
        check("t6_rel_req_valid", imem_req_valid, 1);
        check("t6_rel_addr", imem_req_addr, 16'h0000);
        check("t6_rel_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
